macc_accum: RTL

//  Downstream stage of the radix-4 Booth pipelined multiplier (Mul) in the MACC datapath.

---
 rtl/macc_pkg.sv | 31 +++
 rtl/macc_vld_pipe.sv | 30 +++
 rtl/macc_accum.sv | 108 ++++++++++
 3 files changed

// File: rtl/macc_pkg.sv
// Shared constants and helpers for the MACC accumulation stage that follows the
// radix-4 Booth multiplier.
package macc_pkg;

  localparam int PROD_W    = 15;
  localparam int MUL_LAT   = 8;
  localparam int KLEN_DEF  = 9;
  localparam int ACC_W_DEF = 20;
  localparam int OUT_W_DEF = 16;

  localparam logic signed [OUT_W_DEF-1:0] SAT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic signed [OUT_W_DEF-1:0] SAT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_e;

  // Classifies a wide signed sum against the range of an out_w-bit signed result.
  function automatic sat_e sat(input logic signed [31:0] v, input int out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return SAT_POS;
    else if (v < lo) return SAT_NEG;
    else             return SAT_NONE;
  endfunction

endpackage

// File: rtl/macc_vld_pipe.sv
// Delay line that carries op_valid alongside the multiplier latency, so the
// accumulator knows which product cycles are real.
module macc_vld_pipe
  import macc_pkg::*;
#(
  parameter int DEPTH = MUL_LAT
) (
  input  logic clk,
  input  logic clr_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = vld_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign vld_o = sr_q[DEPTH-1];

endmodule

// File: rtl/macc_accum.sv
// Window accumulator: sums KLEN products from the Booth multiplier and presents
// one saturated result per window on a valid/ready output.
module macc_accum
  import macc_pkg::*;
#(
  parameter int KLEN  = KLEN_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  input  logic                     flush,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     drop_err,
  output logic [$clog2(KLEN)-1:0]  tap_cnt
);

  localparam int TAP_W = $clog2(KLEN);
  localparam logic [TAP_W-1:0]       LAST_TAP = TAP_W'(KLEN - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, sum;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;
  logic                    drop_q, drop_d;
  sat_e                    sat_k;

  // Flush also empties the delay line, so products already inside Mul are ignored.
  macc_vld_pipe #(.DEPTH(MUL_LAT)) u_vld_pipe (
    .clk   (clk),
    .clr_i (rst | flush),
    .vld_i (op_valid),
    .vld_o (prod_vld)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch leaves it unassigned (no latch).
    acc_d   = acc_q;
    tap_d   = tap_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    drop_d  = drop_q;

    acc_base = (tap_q == '0) ? '0 : acc_q;
    sum      = acc_base + ACC_W'(prod);
    sat_k    = sat(32'(sum), OUT_W);

    if (valid_q && out_ready) valid_d = 1'b0;

    if (flush) begin
      acc_d = '0;
      tap_d = '0;
    end else if (prod_vld) begin
      acc_d = sum;
      if (tap_q == LAST_TAP) begin
        tap_d = '0;
        if (valid_q && !out_ready) begin
          drop_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          sat_d   = (sat_k != SAT_NONE);
          case (sat_k)
            SAT_POS: data_d = OUT_MAX;
            SAT_NEG: data_d = OUT_MIN;
            default: data_d = sum[OUT_W-1:0];
          endcase
        end
      end else begin
        tap_d = tap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      tap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sat   = sat_q;
  assign drop_err  = drop_q;
  assign tap_cnt   = tap_q;

endmodule
